// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32I instruction fetch stage: pc, imem req/ack, 2-entry output buffer, redirect/drain
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pc4
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {FETCH = 1'b0, DRAIN = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] drain_addr_q, drain_addr_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_inst_q, skid_inst_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        inst_valid_q, inst_valid_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic [31:0] inst_pc4_q, inst_pc4_d;

    logic complete;
    logic accept;
    logic fetch_done;

    assign complete   = imem_req && imem_ack;
    assign accept     = inst_valid_q && !stall;
    assign fetch_done = complete && (state_q == FETCH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Only a redirect that abandons an un-acked request needs to drain it
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH: if (redirect && imem_req && !imem_ack) state_d = DRAIN;
            DRAIN: if (complete) state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        imem_req  = rst_n && ((state_q == DRAIN) || !skid_valid_q);
        imem_addr = (state_q == DRAIN) ? drain_addr_q : pc_q;
    end

    always_comb begin
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        skid_valid_d = skid_valid_q;
        skid_inst_d  = skid_inst_q;
        skid_pc_d    = skid_pc_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_pc4_d   = inst_pc4_q;

        if (accept) begin
            if (skid_valid_q) begin
                inst_d       = skid_inst_q;
                inst_pc_d    = skid_pc_q;
                inst_pc4_d   = skid_pc_q + 32'd4;
                skid_valid_d = 1'b0;
            end else begin
                inst_valid_d = 1'b0;
            end
        end

        // imem_req is low while the skid is full, so a completion never meets a skid drain
        if (fetch_done) begin
            pc_d = pc_q + 32'd4;
            if (!inst_valid_q || accept) begin
                inst_valid_d = 1'b1;
                inst_d       = imem_rdata;
                inst_pc_d    = pc_q;
                inst_pc4_d   = pc_q + 32'd4;
            end else begin
                skid_valid_d = 1'b1;
                skid_inst_d  = imem_rdata;
                skid_pc_d    = pc_q;
            end
        end

        if (redirect) begin
            pc_d         = {redirect_pc[31:2], 2'b00};
            inst_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            if ((state_q == FETCH) && imem_req && !imem_ack) drain_addr_d = pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            drain_addr_q <= 32'h0;
            skid_valid_q <= 1'b0;
            skid_inst_q  <= NOP;
            skid_pc_q    <= 32'h0;
            inst_valid_q <= 1'b0;
            inst_q       <= NOP;
            inst_pc_q    <= 32'h0;
            inst_pc4_q   <= 32'd4;
        end else begin
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            skid_valid_q <= skid_valid_d;
            skid_inst_q  <= skid_inst_d;
            skid_pc_q    <= skid_pc_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_pc4_q   <= inst_pc4_d;
        end
    end

    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign inst_pc4   = inst_pc4_q;
endmodule
